// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline-control slice: forwarding mux sources and
// stage indices used to address the per-stage enable/clear vectors.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_SRC_RF  = 2'd0,
    FWD_SRC_EXE = 2'd1,
    FWD_SRC_MEM = 2'd2
  } fwd_src_e;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EXE = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;
  localparam int NUM_STG = 5;

  typedef logic [NUM_STG-1:0] stage_vec_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the ID-stage decoder / pipeline and the hazard controller.
// The master side is the pipeline; the slave side is hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              debug_en;
  logic              debug_step;
  logic [REG_AW-1:0] id_rs_addr;
  logic [REG_AW-1:0] id_rt_addr;
  logic              id_rs_used;
  logic              id_rt_used;
  logic              id_is_branch;
  logic [REG_AW-1:0] exe_wb_addr;
  logic              exe_wb_wen;
  logic              exe_mem_ren;
  logic [REG_AW-1:0] mem_wb_addr;
  logic              mem_wb_wen;
  logic              mem_busy;

  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              if_en, id_en, exe_en, mem_en, wb_en;
  logic              if_rst, id_rst, exe_rst, mem_rst, wb_rst;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output debug_en, debug_step, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
           id_is_branch, exe_wb_addr, exe_wb_wen, exe_mem_ren, mem_wb_addr,
           mem_wb_wen, mem_busy,
    input  fwd_a_sel, fwd_b_sel, if_en, id_en, exe_en, mem_en, wb_en,
           if_rst, id_rst, exe_rst, mem_rst, wb_rst, stall_cnt, flush_cnt
  );

  modport slave (
    input  debug_en, debug_step, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
           id_is_branch, exe_wb_addr, exe_wb_wen, exe_mem_ren, mem_wb_addr,
           mem_wb_wen, mem_busy,
    output fwd_a_sel, fwd_b_sel, if_en, id_en, exe_en, mem_en, wb_en,
           if_rst, id_rst, exe_rst, mem_rst, wb_rst, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// Per-operand RAW check against EXE/MEM writeback: picks the operand source
// and flags a stall when the value cannot be forwarded in time.
module hazard_ctrl_fwd_unit
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              used_i,
  input  logic [REG_AW-1:0] addr_i,
  input  logic [REG_AW-1:0] exe_addr_i,
  input  logic              exe_wen_i,
  input  logic              exe_ren_i,
  input  logic [REG_AW-1:0] mem_addr_i,
  input  logic              mem_wen_i,
  output fwd_src_e          sel_o,
  output logic              stall_o
);
  logic exe_hit;
  logic mem_hit;

  assign exe_hit = used_i && (addr_i != '0) && exe_wen_i && (addr_i == exe_addr_i);
  assign mem_hit = used_i && (addr_i != '0) && mem_wen_i && (addr_i == mem_addr_i);

  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel_o   = FWD_SRC_RF;
    stall_o = 1'b0;
    if (FWD_EN) begin
      // EXE is the younger producer, so it shadows a MEM match on the same register.
      if (exe_hit) begin
        if (exe_ren_i) stall_o = 1'b1;
        else           sel_o   = FWD_SRC_EXE;
      end else if (mem_hit) begin
        sel_o = FWD_SRC_MEM;
      end
    end else begin
      stall_o = exe_hit | mem_hit;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline control for the 5-stage core: forwarding selects, load-use / RAW
// stalls, branch flush bubbles, memory freeze, debug single-step and perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter bit FWD_EN   = 1'b1,
  parameter int BR_FLUSH = 3,
  parameter int CNT_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);
  localparam logic [2:0] FLUSH_LOAD = 3'(BR_FLUSH - 1);

  fwd_src_e   sel_a, sel_b;
  logic       stall_a, stall_b, reg_stall;
  logic       step_pulse, hold;
  stage_vec_t en, clr;
  logic       stall_hit, flow;

  logic             step_prev_q;
  logic [2:0]       flush_rem_q, flush_rem_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  hazard_ctrl_fwd_unit #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_a (
    .used_i    (bus.id_rs_used),
    .addr_i    (bus.id_rs_addr),
    .exe_addr_i(bus.exe_wb_addr),
    .exe_wen_i (bus.exe_wb_wen),
    .exe_ren_i (bus.exe_mem_ren),
    .mem_addr_i(bus.mem_wb_addr),
    .mem_wen_i (bus.mem_wb_wen),
    .sel_o     (sel_a),
    .stall_o   (stall_a)
  );

  hazard_ctrl_fwd_unit #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_b (
    .used_i    (bus.id_rt_used),
    .addr_i    (bus.id_rt_addr),
    .exe_addr_i(bus.exe_wb_addr),
    .exe_wen_i (bus.exe_wb_wen),
    .exe_ren_i (bus.exe_mem_ren),
    .mem_addr_i(bus.mem_wb_addr),
    .mem_wen_i (bus.mem_wb_wen),
    .sel_o     (sel_b),
    .stall_o   (stall_b)
  );

  assign reg_stall  = stall_a | stall_b;
  assign step_pulse = bus.debug_step & ~step_prev_q;
  assign hold       = bus.debug_en & ~step_pulse;

  always_comb begin
    en        = '1;
    clr       = '0;
    stall_hit = 1'b0;
    flow      = 1'b0;
    if (rst) begin
      clr = '1;
    end else if (hold || bus.mem_busy) begin
      en = '0;
    end else if (reg_stall) begin
      // Hold IF/ID with the dependent instruction, send a bubble into EXE.
      en[STG_IF]   = 1'b0;
      en[STG_ID]   = 1'b0;
      clr[STG_EXE] = 1'b1;
      stall_hit    = 1'b1;
    end else begin
      flow        = 1'b1;
      clr[STG_ID] = bus.id_is_branch | (flush_rem_q != 3'd0);
    end
  end

  // A branch only counts as accepted once it leaves ID, so a stalled branch reloads later.
  always_comb begin
    flush_rem_d = flush_rem_q;
    if (flow) begin
      if (bus.id_is_branch)          flush_rem_d = FLUSH_LOAD;
      else if (flush_rem_q != 3'd0)  flush_rem_d = flush_rem_q - 3'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_prev_q <= 1'b0;
      flush_rem_q <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      step_prev_q <= bus.debug_step;
      flush_rem_q <= flush_rem_d;
      if (stall_hit && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flow && clr[STG_ID] && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.fwd_a_sel = sel_a;
  assign bus.fwd_b_sel = sel_b;
  assign bus.if_en     = en[STG_IF];
  assign bus.id_en     = en[STG_ID];
  assign bus.exe_en    = en[STG_EXE];
  assign bus.mem_en    = en[STG_MEM];
  assign bus.wb_en     = en[STG_WB];
  assign bus.if_rst    = clr[STG_IF];
  assign bus.id_rst    = clr[STG_ID];
  assign bus.exe_rst   = clr[STG_EXE];
  assign bus.mem_rst   = clr[STG_MEM];
  assign bus.wb_rst    = clr[STG_WB];
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two configurations driven in lockstep and checked every
// cycle against a behavioural model of the forwarding/stall/flush rules.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       debug_en, debug_step, rs_used, rt_used, is_branch;
  logic       exe_wen, exe_ren, mem_wen, mem_busy;
  logic [4:0] rs_addr, rt_addr, exe_addr, mem_addr;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus0 ();
  hazard_ctrl_if #(.REG_AW(5), .CNT_W(2))  bus1 ();

  assign bus0.debug_en = debug_en;      assign bus1.debug_en = debug_en;
  assign bus0.debug_step = debug_step;  assign bus1.debug_step = debug_step;
  assign bus0.id_rs_addr = rs_addr;     assign bus1.id_rs_addr = rs_addr;
  assign bus0.id_rt_addr = rt_addr;     assign bus1.id_rt_addr = rt_addr;
  assign bus0.id_rs_used = rs_used;     assign bus1.id_rs_used = rs_used;
  assign bus0.id_rt_used = rt_used;     assign bus1.id_rt_used = rt_used;
  assign bus0.id_is_branch = is_branch; assign bus1.id_is_branch = is_branch;
  assign bus0.exe_wb_addr = exe_addr;   assign bus1.exe_wb_addr = exe_addr;
  assign bus0.exe_wb_wen = exe_wen;     assign bus1.exe_wb_wen = exe_wen;
  assign bus0.exe_mem_ren = exe_ren;    assign bus1.exe_mem_ren = exe_ren;
  assign bus0.mem_wb_addr = mem_addr;   assign bus1.mem_wb_addr = mem_addr;
  assign bus0.mem_wb_wen = mem_wen;     assign bus1.mem_wb_wen = mem_wen;
  assign bus0.mem_busy = mem_busy;      assign bus1.mem_busy = mem_busy;

  hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b1), .BR_FLUSH(3), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b0), .BR_FLUSH(5), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  typedef struct {
    int step_prev;
    int flush_left;
    int stall_cnt;
    int flush_cnt;
  } model_t;

  typedef struct {
    int fwd_a, fwd_b, en, clr, stall_cnt, flush_cnt;
  } exp_t;

  model_t m0, m1;
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Source choice for one operand, from the forwarding rules stated plainly.
  function automatic int op_sel(input int fwd_en, input logic used, input logic [4:0] a,
                                output bit stall);
    bit in_exe, in_mem;
    in_exe = used && a != 0 && exe_wen && a == exe_addr;
    in_mem = used && a != 0 && mem_wen && a == mem_addr;
    stall = 0;
    if (fwd_en == 0) begin
      stall = in_exe || in_mem;
      return 0;
    end
    if (in_exe) begin
      if (exe_ren) begin
        stall = 1;
        return 0;
      end
      return 1;
    end
    return in_mem ? 2 : 0;
  endfunction

  task automatic run_model(input int fwd_en, input int br_flush, input int cnt_w,
                           inout model_t m, output exp_t e);
    bit sa, sb, pulse, held, advanced;
    int top;
    top = (1 << cnt_w) - 1;
    e.fwd_a = op_sel(fwd_en, rs_used, rs_addr, sa);
    e.fwd_b = op_sel(fwd_en, rt_used, rt_addr, sb);
    e.stall_cnt = m.stall_cnt;
    e.flush_cnt = m.flush_cnt;
    pulse = debug_step && m.step_prev == 0;
    held = debug_en && !pulse;
    advanced = 0;
    e.en = 5'h1f;
    e.clr = 0;
    if (rst) e.clr = 5'h1f;
    else if (held || mem_busy) e.en = 0;
    else if (sa || sb) begin
      e.en = 5'b11100;
      e.clr = 5'b00100;
      m.stall_cnt = (m.stall_cnt < top) ? m.stall_cnt + 1 : top;
    end else begin
      advanced = 1;
      if (is_branch || m.flush_left > 0) begin
        e.clr = 5'b00010;
        m.flush_cnt = (m.flush_cnt < top) ? m.flush_cnt + 1 : top;
      end
    end
    if (advanced) m.flush_left = is_branch ? br_flush - 1 : (m.flush_left > 0 ? m.flush_left - 1 : 0);
    m.step_prev = debug_step;
    if (rst) m = '{0, 0, 0, 0};
  endtask

  function automatic logic [31:0] en_vec(input logic w, mm, x, d, f);
    return {27'd0, w, mm, x, d, f};
  endfunction

  task automatic tick();
    exp_t e;
    #1;
    run_model(1, 3, 16, m0, e);
    check("dut0.fwd_a", 32'(bus0.fwd_a_sel), e.fwd_a);
    check("dut0.fwd_b", 32'(bus0.fwd_b_sel), e.fwd_b);
    check("dut0.en", en_vec(bus0.wb_en, bus0.mem_en, bus0.exe_en, bus0.id_en, bus0.if_en), e.en);
    check("dut0.rst", en_vec(bus0.wb_rst, bus0.mem_rst, bus0.exe_rst, bus0.id_rst, bus0.if_rst), e.clr);
    check("dut0.stall_cnt", 32'(bus0.stall_cnt), e.stall_cnt);
    check("dut0.flush_cnt", 32'(bus0.flush_cnt), e.flush_cnt);
    run_model(0, 5, 2, m1, e);
    check("dut1.fwd_a", 32'(bus1.fwd_a_sel), e.fwd_a);
    check("dut1.fwd_b", 32'(bus1.fwd_b_sel), e.fwd_b);
    check("dut1.en", en_vec(bus1.wb_en, bus1.mem_en, bus1.exe_en, bus1.id_en, bus1.if_en), e.en);
    check("dut1.rst", en_vec(bus1.wb_rst, bus1.mem_rst, bus1.exe_rst, bus1.id_rst, bus1.if_rst), e.clr);
    check("dut1.stall_cnt", 32'(bus1.stall_cnt), e.stall_cnt);
    check("dut1.flush_cnt", 32'(bus1.flush_cnt), e.flush_cnt);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; debug_en = 0; debug_step = 0; is_branch = 0; mem_busy = 0;
    rs_used = 0; rt_used = 0; rs_addr = 0; rt_addr = 0;
    exe_wen = 0; exe_ren = 0; exe_addr = 0; mem_wen = 0; mem_addr = 0;
  endtask

  initial begin
    m0 = '{0, 0, 0, 0};
    m1 = '{0, 0, 0, 0};
    idle();
    rst = 1;
    @(negedge clk);
    tick();
    rst = 0;

    // Forward from EXE ALU result.
    idle(); rs_used = 1; rs_addr = 3; exe_wen = 1; exe_addr = 3; tick();
    // Load-use stall, then forward from MEM.
    idle(); rt_used = 1; rt_addr = 5; exe_wen = 1; exe_ren = 1; exe_addr = 5; tick();
    idle(); rt_used = 1; rt_addr = 5; mem_wen = 1; mem_addr = 5; tick();
    // MEM match and register zero.
    idle(); rs_used = 1; rs_addr = 7; mem_wen = 1; mem_addr = 7; tick();
    idle(); rs_used = 1; rs_addr = 0; exe_wen = 1; exe_addr = 0; tick();
    // Branch flush with a memory freeze in the middle.
    idle(); is_branch = 1; tick();
    idle(); tick();
    idle(); mem_busy = 1; tick();
    idle(); repeat (6) tick();
    // Debug single-step with a held level.
    idle(); debug_en = 1; repeat (2) tick();
    debug_step = 1; repeat (3) tick();
    debug_step = 0; tick();
    debug_step = 1; tick();
    debug_en = 0; tick();
    // Reset in the middle of a flush, then counter saturation.
    idle(); is_branch = 1; tick();
    idle(); rst = 1; tick();
    idle(); repeat (3) tick();
    idle(); rs_used = 1; rs_addr = 9; exe_wen = 1; exe_ren = 1; exe_addr = 9;
    repeat (5) tick();
    // Stall and branch together: stall wins, branch accepted afterwards.
    is_branch = 1; tick();
    idle(); is_branch = 1; tick();
    idle(); repeat (6) tick();

    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 49) == 0) debug_en = ~debug_en;
      debug_step = ($urandom_range(0, 2) == 0);
      rs_addr    = 5'($urandom_range(0, 3));
      rt_addr    = 5'($urandom_range(0, 3));
      exe_addr   = 5'($urandom_range(0, 3));
      mem_addr   = 5'($urandom_range(0, 3));
      rs_used    = ($urandom_range(0, 9) < 7);
      rt_used    = ($urandom_range(0, 9) < 7);
      exe_wen    = ($urandom_range(0, 9) < 6);
      exe_ren    = ($urandom_range(0, 9) < 3);
      mem_wen    = ($urandom_range(0, 9) < 6);
      is_branch  = ($urandom_range(0, 99) < 15);
      mem_busy   = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised pipeline-control unit for the 5-stage MIPS core; drop-in successor to the stall-only controller's pipeline-control section.
- Adds operand forwarding with load-use detection, a configurable branch-flush depth, a memory-busy freeze, debug single-step edge detection, and saturating stall/flush performance counters.
- Sits beside the ID-stage decoder. Consumes decoded register usage plus EXE/MEM writeback feedback. Drives per-stage en/rst and the forwarding muxes.

Parameters:
- REG_AW, 5, register address width; address 0 is hardwired zero.
- FWD_EN, 1, 1 = forwarding plus load-use stall; 0 = stall on any RAW against EXE or MEM.
- BR_FLUSH, 3, bubbles injected into ID after an accepted jump/branch; legal range 1..7.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- debug_en  in  1  debug suspend mode
- debug_step  in  1  step request, level; rising edge advances one cycle
- id_rs_addr  in  REG_AW  rs of the ID instruction
- id_rt_addr  in  REG_AW  rt of the ID instruction
- id_rs_used  in  1  ID instruction reads rs
- id_rt_used  in  1  ID instruction reads rt
- id_is_branch  in  1  ID instruction is a jump/branch (pc_src != next)
- exe_wb_addr  in  REG_AW  EXE destination register
- exe_wb_wen  in  1  EXE writes a register
- exe_mem_ren  in  1  EXE instruction is a load
- mem_wb_addr  in  REG_AW  MEM destination register
- mem_wb_wen  in  1  MEM writes a register
- mem_busy  in  1  data memory has not acknowledged
- fwd_a_sel  out  2  rs operand source: 0 regfile, 1 EXE ALU result, 2 MEM writeback data
- fwd_b_sel  out  2  rt operand source, same encoding
- if_en, id_en, exe_en, mem_en, wb_en  out  1 each  stage enables
- if_rst, id_rst, exe_rst, mem_rst, wb_rst  out  1 each  stage synchronous clears
- stall_cnt  out  CNT_W  count of register-stall cycles
- flush_cnt  out  CNT_W  count of ID bubbles injected by branches

Behaviour:
- Hazard match per source operand: used && addr != 0 && wen && addr equal.
- Priority when EXE and MEM both match: EXE wins.
- FWD_EN=1:
  - EXE match on a non-load: sel=1.
  - EXE match on a load (exe_mem_ren): reg_stall; sel=0.
  - Else MEM match: sel=2.
  - Else sel=0.
- FWD_EN=0:
  - Any EXE or MEM match asserts reg_stall.
  - fwd_*_sel is always 0.
- Debug:
  - step_prev register samples debug_step every clk.
  - step_pulse = debug_step & ~step_prev.
  - hold = debug_en & ~step_pulse.
- Control priority, combinational, defaults all en=1 and all rst=0:
  1. rst: all *_rst=1.
  2. hold: all en=0.
  3. mem_busy: all en=0 (freeze). No counter changes.
  4. reg_stall: if_en=0, id_en=0, exe_rst=1. stall_cnt increments.
  5. Branch/flush: id_rst=1 when (id_is_branch) or (flush_rem != 0). flush_cnt increments.
- Flush counter flush_rem (3 bits):
  - Updates only in cycles that reach priority level 5 (not held, frozen, or stalled).
  - Accepted branch (id_is_branch): load BR_FLUSH-1.
  - Otherwise, if nonzero, decrement.
  - A branch arriving while flush_rem != 0 reloads the counter; no accumulation.
- Counters saturate at all-ones and never wrap.
- Reset values:
  - step_prev=0, flush_rem=0, stall_cnt=0, flush_cnt=0.
  - During rst: fwd_*_sel still combinational from inputs; all en=1; all rst=1.
- Reset mid-flush or mid-stall: state cleared the next cycle; no residual bubbles.
- Simultaneous reg_stall and id_is_branch: stall wins. The branch is accepted in the first non-stalled cycle, so no flush starts while the branch sits stalled.
- debug_en deassert during a step: normal run resumes the next cycle.

Decomposition:
- Shared package/header (alongside mips_define.vh):
  - FWD_SRC_RF/FWD_SRC_EXE/FWD_SRC_MEM encodings.
  - Stage-index constants.
- Sub-module fwd_unit: purely combinational per-operand match/select. Instantiated twice (rs, rt); each instance returns sel plus a load-use flag.
- Sequential state (step edge, flush counter, performance counters) stays in hazard_ctrl.

Test Plan:
1. FWD_EN=1; ID rs=3 used; EXE wb_addr=3, wen=1, mem_ren=0 -> fwd_a_sel=1, no stall, all en=1.
2. FWD_EN=1; EXE load to r5; ID rt=5 used -> one cycle of if_en=0, id_en=0, exe_rst=1, stall_cnt +1. Next cycle, load now in MEM -> fwd_b_sel=2, no stall.
3. FWD_EN=0; ID rs=7; MEM wb r7 -> reg_stall asserted; fwd_a_sel=0. rs=0 with EXE writing r0 -> no stall.
4. BR_FLUSH=3; id_is_branch for one cycle, then plain instructions -> id_rst high for exactly 3 consecutive cycles; flush_cnt=3. Insert mem_busy in cycle 2 -> all en=0, flush_rem frozen, total bubbles still 3.
5. debug_en=1, debug_step held high -> stages advance exactly one cycle per rising edge; held level gives no extra advance.
6. rst pulse while flush_rem=2 and counters nonzero -> all *_rst=1 that cycle; afterwards counters=0 and no id_rst. Saturation check with CNT_W=2: 5 stall cycles -> stall_cnt=3.
